// File: rtl/riscv_core_irq_pkg.sv
// Shared definitions for the machine external interrupt controller.
//   IRQ_NUM_SRC_DEF : default number of external interrupt sources
//   IRQ_ID_W_DEF    : default claim-ID width ($clog2 of the source count)
//   irq_state_e     : controller FSM states (IDLE, REQ, SERVICE)
package riscv_core_irq_pkg;

  localparam int unsigned IRQ_NUM_SRC_DEF = 8;
  localparam int unsigned IRQ_ID_W_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/riscv_core_irq_arbiter.sv
// Combinational fixed-priority arbiter: the lowest set request index wins.
// Ports:
//   i_req   : request vector (eligible interrupt sources)
//   o_valid : at least one request is set
//   o_id    : index of the winning request (0 when none)
module riscv_core_irq_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);

  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    // Scan from the top down so the lowest set index is the last to assign.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (i_req[i-1]) begin
        o_id = ID_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/riscv_core_irq_ctrl.sv
// Machine external interrupt controller for the RISC-V core.
// Latches raw source lines into a pending register, masks them with a
// software-written enable register, picks the lowest eligible index and
// raises a registered request to the CSR unit. The CSR unit acknowledges
// (claim) and later signals handler completion (mret in WB).
//
// Build option: define RISCV_CORE_IRQ_EDGE_EN for edge-triggered sources
// (pending sets on a rising edge, the claimed bit clears at ack). Without
// it the sources are level-sensitive (pending follows the source lines).
//
// Ports:
//   i_riscv_core_clk          : clock
//   i_riscv_core_rst_n        : asynchronous active-low reset
//   i_riscv_core_irq_src      : raw interrupt source lines
//   i_riscv_core_irq_en_we    : enable-mask write strobe
//   i_riscv_core_irq_en_wdata : new enable mask
//   o_riscv_core_mexternal    : registered external interrupt request
//   i_riscv_core_ack          : CSR-unit acknowledge (claim) pulse
//   i_riscv_core_irq_complete : handler-complete pulse
//   o_riscv_core_irq_id       : requested / claimed source ID
//   o_riscv_core_irq_pending  : pending register
//   o_riscv_core_irq_en       : current enable mask
module riscv_core_irq_ctrl
  import riscv_core_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = IRQ_NUM_SRC_DEF,
  parameter int unsigned ID_W    = IRQ_ID_W_DEF
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst_n,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_src,
  input  logic               i_riscv_core_irq_en_we,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_en_wdata,
  output logic               o_riscv_core_mexternal,
  input  logic               i_riscv_core_ack,
  input  logic               i_riscv_core_irq_complete,
  output logic [ID_W-1:0]    o_riscv_core_irq_id,
  output logic [NUM_SRC-1:0] o_riscv_core_irq_pending,
  output logic [NUM_SRC-1:0] o_riscv_core_irq_en
);

  irq_state_e         r_state;
  irq_state_e         w_state_nxt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] w_eligible;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_id_nxt;
  logic [ID_W-1:0]    w_win_id;
  logic               w_win_valid;
  logic               w_ack_take;
  logic               r_mext;

  assign w_eligible = r_pending & r_en;

  riscv_core_irq_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arbiter (
    .i_req   (w_eligible),
    .o_valid (w_win_valid),
    .o_id    (w_win_id)
  );

  // A claim only happens in REQ with something to claim.
  assign w_ack_take = (r_state == REQ) && i_riscv_core_ack && w_win_valid;

`ifdef RISCV_CORE_IRQ_EDGE_EN
  logic [NUM_SRC-1:0] r_src_q;
  logic               r_hist_vld;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;

  always_comb begin
    // The history register is meaningless until it has captured one real
    // sample; a source already high at reset release is not an edge.
    w_rise = r_hist_vld ? (i_riscv_core_irq_src & ~r_src_q) : '0;
    w_clr  = w_ack_take ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_win_id) : '0;
    // A fresh edge on the claimed bit in the ack cycle survives the clear.
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
  end

  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_src_q    <= '0;
      r_hist_vld <= 1'b0;
    end else begin
      r_src_q    <= i_riscv_core_irq_src;
      r_hist_vld <= 1'b1;
    end
  end
`else
  assign w_pending_nxt = i_riscv_core_irq_src;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = REQ;
          w_id_nxt    = w_win_id;
        end
      end
      REQ: begin
        // Track the current winner so IDLE later holds the last one shown.
        if (w_win_valid) begin
          w_id_nxt = w_win_id;
        end
        if (w_ack_take) begin
          w_state_nxt = SERVICE;
        end else if (!w_win_valid) begin
          w_state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (i_riscv_core_irq_complete) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_en      <= '0;
      r_id      <= '0;
      r_mext    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_id      <= w_id_nxt;
      r_mext    <= (w_state_nxt == REQ);
      if (i_riscv_core_irq_en_we) begin
        r_en <= i_riscv_core_irq_en_wdata;
      end
    end
  end

  // In REQ the ID follows the live winner (a function of registers only),
  // so the ID seen in the ack cycle is exactly the one claimed.
  assign o_riscv_core_irq_id      = ((r_state == REQ) && w_win_valid) ? w_win_id : r_id;
  assign o_riscv_core_mexternal   = r_mext;
  assign o_riscv_core_irq_pending = r_pending;
  assign o_riscv_core_irq_en      = r_en;

endmodule

// File: tb/tb_riscv_core_irq_ctrl.sv
// Self-checking bench for riscv_core_irq_ctrl (default 8 sources).
// Stimulus pushes expected mexternal transitions (direction, ID, cycle)
// into a queue; a monitor pops and compares on every observed transition.
// Register snapshots (reset values, pending) are compared directly.
module tb_riscv_core_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic       en_we;
  logic [7:0] en_wdata;
  logic       mext;
  logic       ack;
  logic       complete;
  logic [2:0] id;
  logic [7:0] pending;
  logic [7:0] en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       rise;
    logic [2:0] id;
    int         cyc;
  } ev_t;

  ev_t  exp_q[$];
  logic prev_mext = 1'b0;

  riscv_core_irq_ctrl #(
    .NUM_SRC (8),
    .ID_W    (3)
  ) dut (
    .i_riscv_core_clk          (clk),
    .i_riscv_core_rst_n        (rst_n),
    .i_riscv_core_irq_src      (src),
    .i_riscv_core_irq_en_we    (en_we),
    .i_riscv_core_irq_en_wdata (en_wdata),
    .o_riscv_core_mexternal    (mext),
    .i_riscv_core_ack          (ack),
    .i_riscv_core_irq_complete (complete),
    .o_riscv_core_irq_id       (id),
    .o_riscv_core_irq_pending  (pending),
    .o_riscv_core_irq_en       (en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every mexternal transition must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (mext !== prev_mext) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mext actual mext=%0b id=%0d cyc=%0d, required no transition",
                 mext, id, cyc);
      end else begin
        e = exp_q.pop_front();
        if (mext !== e.rise || id !== e.id || cyc != e.cyc) begin
          errors++;
          $display("FAIL mext_event actual mext=%0b id=%0d cyc=%0d, required mext=%0b id=%0d cyc=%0d",
                   mext, id, cyc, e.rise, e.id, e.cyc);
        end
      end
      prev_mext = mext;
    end
  end

  task automatic push_ev(input logic r, input logic [2:0] i, input int c);
    ev_t e;
    e.rise = r;
    e.id   = i;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_en(input logic [7:0] v);
    en_we    = 1'b1;
    en_wdata = v;
    tick();
    en_we    = 1'b0;
  endtask

  // Claim while in REQ; mexternal drops on the sampling edge.
  task automatic do_ack(input logic [2:0] i);
    ack = 1'b1;
    push_ev(1'b0, i, cyc + 1);
    tick();
    ack = 1'b0;
  endtask

  task automatic do_complete();
    complete = 1'b1;
    tick();
    complete = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    src      = '0;
    en_we    = 1'b0;
    en_wdata = '0;
    ack      = 1'b0;
    complete = 1'b0;
    repeat (2) tick();
    chk("reset_mext", 32'(mext), 32'd0);
    chk("reset_id", 32'(id), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Enable all sources.
    wr_en(8'hFF);
    chk("en_write", 32'(en), 32'hFF);
    tick();

    // Single source: pending after one edge, request after two.
    src[5] = 1'b1;
    push_ev(1'b1, 3'd5, cyc + 2);
    tick();
    chk("pending_src5", 32'(pending), 32'h20);
    tick();
    do_ack(3'd5);
    src = '0;
    tick();
    chk("pending_after_ack5", 32'(pending), 32'h00);
    do_complete();
    repeat (2) tick();

    // Two sources together: lowest index first, the other after complete.
    src = 8'h44;
    push_ev(1'b1, 3'd2, cyc + 2);
    repeat (2) tick();
    do_ack(3'd2);
    src = 8'h40;
    tick();
    push_ev(1'b1, 3'd6, cyc + 2);
    do_complete();
    tick();
    do_ack(3'd6);
    src = '0;
    tick();
    do_complete();
    repeat (2) tick();

    // Masked source stays pending; enabling it requests two cycles later.
    wr_en(8'h00);
    src[3] = 1'b1;
    tick();
    chk("pending_masked3", 32'(pending), 32'h08);
    repeat (4) tick();
    push_ev(1'b1, 3'd3, cyc + 2);
    wr_en(8'h08);
    tick();
    do_ack(3'd3);
    src = '0;
    tick();
    do_complete();
    repeat (2) tick();
    wr_en(8'hFF);
    tick();

    // Mask removed while in REQ: back to IDLE, stray ack ignored.
    src[4] = 1'b1;
    push_ev(1'b1, 3'd4, cyc + 2);
    repeat (2) tick();
    push_ev(1'b0, 3'd4, cyc + 2);
    wr_en(8'h00);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (2) tick();
    chk("id_hold_idle", 32'(id), 32'd4);
    push_ev(1'b1, 3'd4, cyc + 2);
    wr_en(8'hFF);
    tick();
    do_ack(3'd4);
    src = '0;
    tick();
    do_complete();
    repeat (2) tick();

    // Source held high across ack and complete.
    src[1] = 1'b1;
    push_ev(1'b1, 3'd1, cyc + 2);
    repeat (2) tick();
    do_ack(3'd1);
    tick();
`ifndef RISCV_CORE_IRQ_EDGE_EN
    push_ev(1'b1, 3'd1, cyc + 2);
`endif
    do_complete();
    repeat (2) tick();
`ifndef RISCV_CORE_IRQ_EDGE_EN
    do_ack(3'd1);
    src = '0;
    tick();
    do_complete();
`else
    chk("edge_no_rereq_pending", 32'(pending), 32'h00);
    src = '0;
`endif
    repeat (2) tick();

`ifdef RISCV_CORE_IRQ_EDGE_EN
    // New edge on the claimed bit in the ack cycle keeps it pending.
    src[5] = 1'b1;
    push_ev(1'b1, 3'd5, cyc + 2);
    tick();
    src[5] = 1'b0;
    tick();
    src[5] = 1'b1;
    do_ack(3'd5);
    chk("set_over_clear", 32'(pending), 32'h20);
    push_ev(1'b1, 3'd5, cyc + 2);
    do_complete();
    tick();
    do_ack(3'd5);
    src = '0;
    tick();
    do_complete();
    repeat (2) tick();
`endif

    // Reset in SERVICE with pending 0x81.
    src = 8'h81;
    push_ev(1'b1, 3'd0, cyc + 2);
    repeat (2) tick();
    do_ack(3'd0);
    src = 8'h80;
    tick();
    src = 8'h81;
    tick();
    chk("pending_service", 32'(pending), 32'h81);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mext", 32'(mext), 32'd0);
    chk("async_rst_id", 32'(id), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_en", 32'(en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`ifndef RISCV_CORE_IRQ_EDGE_EN
    push_ev(1'b1, 3'd0, cyc + 2);
`endif
    wr_en(8'hFF);
    repeat (4) tick();
`ifndef RISCV_CORE_IRQ_EDGE_EN
    chk("post_rst_pending", 32'(pending), 32'h81);
    do_ack(3'd0);
    src = '0;
    tick();
    do_complete();
`else
    chk("post_rst_pending", 32'(pending), 32'h00);
    src = '0;
`endif
    repeat (4) tick();

    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
